// File: rtl/reg_bank_s8_seq_pkg.sv
// Shared types and constants for the RegBankS8 program sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_bank_s8_seq_pkg;

   // Width of the loop and wait down-counters.
   localparam int CNT_W = 8;

   // Sequencer opcodes, taken from ROM word bits [15:12].
   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ISSUE = 4'h1;
   localparam logic [3:0] OP_JMP   = 4'h2;
   localparam logic [3:0] OP_WAIT  = 4'h3;
   localparam logic [3:0] OP_LDC   = 4'h4;
   localparam logic [3:0] OP_DJNZ  = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'h6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HALT  = 3'd4,
      ST_ERROR = 3'd5
   } seq_state_t;

   // States in which a program is actively running.
   function automatic logic is_busy_state(input seq_state_t s);
      return (s inside {ST_FETCH, ST_EXEC, ST_WAIT});
   endfunction

endpackage

// File: rtl/reg_bank_s8_seq_counter.sv
// seq_counter: loadable 8-bit down-counter with zero flag; saturates at 0.
// Latency: load/decrement visible one cycle after the request.
// Backpressure: none; load has priority over decrement.
//   clock, reset : clock and async active-low reset (clears count)
//   load,load_val: synchronous load of a new count
//   dec          : decrement by one unless already zero
//   cnt, zero    : registered count and its zero flag
module reg_bank_s8_seq_counter
   import reg_bank_s8_seq_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/reg_bank_s8_seq.sv
// Program sequencer feeding RegBankS8: fetches ROM words, runs flow control, forwards ISSUE payloads.
// Latency: 2 cycles per word (FETCH+EXEC), WAIT n adds n; inst_en pulses the cycle after EXEC.
// Backpressure: none; stop aborts to IDLE next cycle (wins over start), start ignored while busy.
//   clock, reset    : clock, async active-low reset
//   start, stop     : run from address 0 / abort to IDLE
//   rom_addr,rom_data: synchronous ROM port (data one cycle after address)
//   inst, inst_en   : registered instruction and one-cycle valid pulse
//   busy,halted,error: status; halted/error are sticky until restart
module reg_bank_s8_seq
   import reg_bank_s8_seq_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int INST_WIDTH = 12
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [15:0]           rom_data,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  inst_en,
   output logic                  busy,
   output logic                  halted,
   output logic                  error
);

   seq_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  inst_en_q, inst_en_d;
   logic                  busy_q, busy_d;
   logic                  halted_q, halted_d;
   logic                  error_q, error_d;

   logic                  wait_load, wait_dec, wait_zero;
   logic                  loop_load, loop_dec, loop_zero;
   logic [CNT_W-1:0]      wait_cnt, loop_cnt;

   logic [3:0]            opcode;
   logic [11:0]           payload;
   logic [ADDR_WIDTH-1:0] pc_inc;

   assign opcode  = rom_data[15:12];
   assign payload = rom_data[11:0];
   assign pc_inc  = pc_q + ADDR_WIDTH'(1);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_en_d = 1'b0;
      halted_d  = halted_q;
      error_d   = error_q;
      wait_load = 1'b0;
      wait_dec  = 1'b0;
      loop_load = 1'b0;
      loop_dec  = 1'b0;

      if (stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_FETCH;
                  pc_d    = '0;
               end
            end
            // pc drives rom_addr during FETCH; the word arrives in EXEC.
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
               state_d = ST_FETCH;
               pc_d    = pc_inc;
               case (opcode)
                  OP_NOP: ;
                  OP_ISSUE: begin
                     inst_d    = payload[INST_WIDTH-1:0];
                     inst_en_d = 1'b1;
                  end
                  OP_JMP: pc_d = payload[ADDR_WIDTH-1:0];
                  OP_WAIT: begin
                     // WAIT 0 behaves as NOP; otherwise hold pc until the stall ends.
                     if (payload[7:0] != 8'd0) begin
                        wait_load = 1'b1;
                        state_d   = ST_WAIT;
                        pc_d      = pc_q;
                     end
                  end
                  OP_LDC: loop_load = 1'b1;
                  OP_DJNZ: begin
                     // Branch only when the count after decrementing is still nonzero.
                     loop_dec = 1'b1;
                     if (!loop_zero && (loop_cnt != CNT_W'(1))) begin
                        pc_d = payload[ADDR_WIDTH-1:0];
                     end
                  end
                  OP_HALT: begin
                     halted_d = 1'b1;
                     state_d  = ST_HALT;
                     pc_d     = pc_q;
                  end
                  default: begin
                     error_d = 1'b1;
                     state_d = ST_ERROR;
                     pc_d    = pc_q;
                  end
               endcase
            end
            ST_WAIT: begin
               if (wait_zero || (wait_cnt == CNT_W'(1))) begin
                  state_d = ST_FETCH;
                  pc_d    = pc_inc;
               end else begin
                  wait_dec = 1'b1;
               end
            end
            ST_HALT, ST_ERROR: begin
               if (start) begin
                  state_d  = ST_FETCH;
                  pc_d     = '0;
                  halted_d = 1'b0;
                  error_d  = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = is_busy_state(state_d);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pc_q      <= '0;
         inst_q    <= '0;
         inst_en_q <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_en_q <= inst_en_d;
         busy_q    <= busy_d;
         halted_q  <= halted_d;
         error_q   <= error_d;
      end
   end

   reg_bank_s8_seq_counter u_wait_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (wait_load),
      .load_val (payload[7:0]),
      .dec      (wait_dec),
      .cnt      (wait_cnt),
      .zero     (wait_zero)
   );

   reg_bank_s8_seq_counter u_loop_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (loop_load),
      .load_val (payload[7:0]),
      .dec      (loop_dec),
      .cnt      (loop_cnt),
      .zero     (loop_zero)
   );

   assign rom_addr = pc_q;
   assign inst     = inst_q;
   assign inst_en  = inst_en_q;
   assign busy     = busy_q;
   assign halted   = halted_q;
   assign error    = error_q;

endmodule
